// File: rtl/fir_decim_coef_ctrl.sv
// Coefficient reload sequencer for the FIR decimator: streams host coefficients into the
// decimator coef port, gates input samples during LOAD and masks results until the delay line refills.
module fir_decim_coef_ctrl #(
    parameter int FILTER_ORDER = 256,
    parameter int DATA_WIDTH   = 16,
    parameter int COEF_WIDTH   = 16,
    parameter int OUT_WIDTH    = 16,
    parameter int COEF_AWIDTH  = $clog2(FILTER_ORDER),
    parameter int DROP_WIDTH   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_start_i,
    input  logic [COEF_WIDTH-1:0]  coef_i,
    input  logic                   coef_val_i,
    output logic                   coef_rdy_o,
    output logic                   coef_we_o,
    output logic [COEF_AWIDTH-1:0] coef_addr_o,
    output logic [COEF_WIDTH-1:0]  coef_data_o,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic                   data_val_i,
    output logic [DATA_WIDTH-1:0]  fir_data_o,
    output logic                   fir_data_val_o,
    input  logic [OUT_WIDTH-1:0]   fir_res_i,
    input  logic                   fir_res_val_i,
    output logic [OUT_WIDTH-1:0]   res_o,
    output logic                   res_val_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [DROP_WIDTH-1:0]  drop_cnt_o,
    output logic                   err_o
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

    localparam logic [COEF_AWIDTH-1:0] LAST = COEF_AWIDTH'(FILTER_ORDER - 1);

    state_t                 state;
    logic [COEF_AWIDTH-1:0] addr;
    logic [COEF_AWIDTH-1:0] fill;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            addr           <= '0;
            fill           <= '0;
            coef_rdy_o     <= 1'b0;
            coef_we_o      <= 1'b0;
            coef_addr_o    <= '0;
            coef_data_o    <= '0;
            fir_data_o     <= '0;
            fir_data_val_o <= 1'b0;
            res_o          <= '0;
            res_val_o      <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            drop_cnt_o     <= '0;
            err_o          <= 1'b0;
        end else begin
            coef_we_o      <= 1'b0;
            done_o         <= 1'b0;
            fir_data_o     <= data_i;
            fir_data_val_o <= data_val_i && (state != LOAD);
            res_o          <= fir_res_i;
            // results are only trustworthy once the delay line holds fresh samples
            res_val_o      <= fir_res_val_i && (state == IDLE);

            case (state)
                IDLE: begin
                    if (load_start_i) begin
                        state      <= LOAD;
                        addr       <= '0;
                        drop_cnt_o <= '0;
                        coef_rdy_o <= 1'b1;
                        busy_o     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_start_i)
                        err_o <= 1'b1;
                    if (data_val_i && (drop_cnt_o != {DROP_WIDTH{1'b1}}))
                        drop_cnt_o <= drop_cnt_o + 1'b1;
                    if (coef_val_i && coef_rdy_o) begin
                        coef_we_o   <= 1'b1;
                        coef_addr_o <= addr;
                        coef_data_o <= coef_i;
                        addr        <= addr + 1'b1;
                        if (addr == LAST) begin
                            state      <= FLUSH;
                            fill       <= '0;
                            coef_rdy_o <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    // a start coinciding with completion is still seen as busy
                    if (load_start_i)
                        err_o <= 1'b1;
                    if (data_val_i) begin
                        fill <= fill + 1'b1;
                        if (fill == LAST) begin
                            state  <= IDLE;
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    coef_rdy_o <= 1'b0;
                    busy_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_decim_coef_ctrl.sv
// Randomized bench for fir_decim_coef_ctrl (FILTER_ORDER=8); a second instance with a
// 2-bit drop counter shares the inputs to exercise saturation.
module tb_fir_decim_coef_ctrl;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic [15:0] coef = '0;
    logic        coef_val = 1'b0;
    logic [15:0] data = '0;
    logic        data_val = 1'b0;
    logic [15:0] fir_res = '0;
    logic        fir_res_val = 1'b0;

    logic        coef_rdy, coef_we, fir_data_val, res_val, busy, done, err;
    logic [2:0]  coef_addr;
    logic [15:0] coef_data, fir_data, res, drop;

    logic        coef_rdy2, coef_we2, fir_data_val2, res_val2, busy2, done2, err2;
    logic [2:0]  coef_addr2;
    logic [15:0] coef_data2, fir_data2, res2;
    logic [1:0]  drop2;

    always #5 clk = ~clk;

    fir_decim_coef_ctrl #(.FILTER_ORDER(N)) dut (
        .clk_i(clk), .rst_i(rst), .load_start_i(load_start),
        .coef_i(coef), .coef_val_i(coef_val), .coef_rdy_o(coef_rdy),
        .coef_we_o(coef_we), .coef_addr_o(coef_addr), .coef_data_o(coef_data),
        .data_i(data), .data_val_i(data_val), .fir_data_o(fir_data), .fir_data_val_o(fir_data_val),
        .fir_res_i(fir_res), .fir_res_val_i(fir_res_val), .res_o(res), .res_val_o(res_val),
        .busy_o(busy), .done_o(done), .drop_cnt_o(drop), .err_o(err));

    fir_decim_coef_ctrl #(.FILTER_ORDER(N), .DROP_WIDTH(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .load_start_i(load_start),
        .coef_i(coef), .coef_val_i(coef_val), .coef_rdy_o(coef_rdy2),
        .coef_we_o(coef_we2), .coef_addr_o(coef_addr2), .coef_data_o(coef_data2),
        .data_i(data), .data_val_i(data_val), .fir_data_o(fir_data2), .fir_data_val_o(fir_data_val2),
        .fir_res_i(fir_res), .fir_res_val_i(fir_res_val), .res_o(res2), .res_val_o(res_val2),
        .busy_o(busy2), .done_o(done2), .drop_cnt_o(drop2), .err_o(err2));

    typedef struct { int addr; int data; int cyc; } wr_t;
    wr_t wr_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [15:0] cf [N];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (coef_we === 1'b1) wr_q.push_back('{int'(coef_addr), int'(coef_data), cyc});

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_start = 0; coef_val = 0; data_val = 0; fir_res_val = 0;
    endtask

    // Pulses start, then feeds cf[0..N-1]; nsamp samples go in on the first LOAD cycles.
    task automatic run_load(input bit throttle, input int nsamp, input int start_at, output int drops);
        int sent, it;
        bit started;
        wr_q.delete();
        load_start = 1; step(); load_start = 0;
        total++;
        if (coef_rdy !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL load_enter rdy=%b busy=%b want 1 1", coef_rdy, busy);
        end
        sent = 0; it = 0; drops = 0; started = 0;
        while (sent < N && it < 200) begin
            coef_val = throttle ? 1'($urandom % 2) : 1'b1;
            coef = cf[sent];
            data_val = (it < nsamp);
            data = 16'($urandom);
            fir_res_val = 1'($urandom); fir_res = 16'($urandom);
            load_start = (start_at >= 0 && !started && sent == start_at);
            if (load_start) started = 1;
            if (data_val) drops++;
            if (coef_val) sent++;
            it++;
            step();
            total++;
            if (fir_data_val !== 1'b0 || res_val !== 1'b0) begin
                bad++; $display("FAIL load_mask fir_val=%b res_val=%b want 0 0", fir_data_val, res_val);
            end
            total++;
            if (coef_rdy !== (sent < N) || busy !== 1'b1) begin
                bad++; $display("FAIL load_rdy rdy=%b busy=%b want %b 1", coef_rdy, busy, sent < N);
            end
        end
        idle_inputs();
    endtask

    task automatic check_coefs(input string name, input bit consecutive);
        @(negedge clk); #1;
        total++;
        if (wr_q.size() != N) begin
            bad++; $display("FAIL %s_wr_count got=%0d want=%0d", name, wr_q.size(), N);
        end else begin
            for (int i = 0; i < N; i++) begin
                total++;
                if (wr_q[i].addr != i || wr_q[i].data != int'(cf[i])) begin
                    bad++; $display("FAIL %s_wr%0d addr=%0d data=%0d want %0d %0d", name, i, wr_q[i].addr, wr_q[i].data, i, cf[i]);
                end
                if (consecutive && i > 0) begin
                    total++;
                    if (wr_q[i].cyc != wr_q[i-1].cyc + 1) begin
                        bad++; $display("FAIL %s_gap cyc=%0d want=%0d", name, wr_q[i].cyc, wr_q[i-1].cyc + 1);
                    end
                end
            end
        end
    endtask

    // Feeds N samples with random gaps; results must stay masked until done, then pass.
    task automatic run_flush(input bit start_on_last);
        int got, it;
        bit last, pv;
        logic [15:0] pd, rv;
        got = 0; it = 0;
        while (got < N && it < 200) begin
            data_val = 1'($urandom % 2); data = 16'($urandom);
            fir_res_val = it[0]; fir_res = 16'($urandom);
            last = data_val && (got == N - 1);
            load_start = start_on_last && last;
            pv = data_val; pd = data;
            if (data_val) got++;
            it++;
            step();
            total++;
            if (fir_data_val !== pv || (pv && fir_data !== pd)) begin
                bad++; $display("FAIL flush_pass val=%b data=%h want %b %h", fir_data_val, fir_data, pv, pd);
            end
            total++;
            if (res_val !== 1'b0 || done !== last || busy !== !last) begin
                bad++; $display("FAIL flush_state res_val=%b done=%b busy=%b want 0 %b %b", res_val, done, busy, last, !last);
            end
        end
        idle_inputs();
        rv = 16'($urandom);
        fir_res = rv; fir_res_val = 1;
        step();
        fir_res_val = 0;
        total++;
        if (res_val !== 1'b1 || res !== rv || done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL idle_result res_val=%b res=%h done=%b busy=%b want 1 %h 0 0", res_val, res, done, busy, rv);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; step(); step();
        total++;
        if ({coef_rdy, coef_we, fir_data_val, res_val, busy, done, err} !== 7'b0 || drop !== 16'd0 || coef_addr !== 3'd0) begin
            bad++; $display("FAIL reset rdy=%b we=%b fv=%b rv=%b busy=%b done=%b err=%b drop=%0d want all 0",
                            coef_rdy, coef_we, fir_data_val, res_val, busy, done, err, drop);
        end
        rst = 0; step();
    endtask

    task automatic test_load_b2b();
        int d;
        for (int i = 0; i < N; i++) cf[i] = 16'(i + 1);
        run_load(0, 0, -1, d);
        check_coefs("b2b", 1);
        total++;
        if (drop !== 16'd0 || busy !== 1'b1) begin
            bad++; $display("FAIL b2b_drop drop=%0d busy=%b want 0 1", drop, busy);
        end
    endtask

    task automatic test_flush();
        run_flush(0);
    endtask

    task automatic test_drop();
        int d;
        for (int i = 0; i < N; i++) cf[i] = 16'($urandom);
        run_load(1, 5, -1, d);
        check_coefs("drop", 0);
        total++;
        if (drop !== 16'd5 || err !== 1'b0) begin
            bad++; $display("FAIL drop_cnt drop=%0d err=%b want 5 0", drop, err);
        end
        run_flush(0);
    endtask

    task automatic test_start_busy();
        int d;
        for (int i = 0; i < N; i++) cf[i] = 16'($urandom);
        run_load(1, 0, 3, d);
        check_coefs("busy_start", 0);
        total++;
        if (err !== 1'b1) begin
            bad++; $display("FAIL err_set err=%b want 1", err);
        end
        run_flush(1);
        total++;
        if (err !== 1'b1) begin
            bad++; $display("FAIL err_sticky err=%b want 1", err);
        end
    endtask

    task automatic test_reset_mid();
        load_start = 1; step(); load_start = 0;
        for (int i = 0; i < 4; i++) begin
            coef_val = 1; coef = 16'($urandom); data_val = 1; step();
        end
        idle_inputs();
        total++;
        if (drop !== 16'd4 || busy !== 1'b1) begin
            bad++; $display("FAIL pre_reset drop=%0d busy=%b want 4 1", drop, busy);
        end
        rst = 1; step(); rst = 0;
        total++;
        if (coef_rdy !== 1'b0 || busy !== 1'b0 || drop !== 16'd0 || err !== 1'b0) begin
            bad++; $display("FAIL mid_reset rdy=%b busy=%b drop=%0d err=%b want 0 0 0 0", coef_rdy, busy, drop, err);
        end
        coef_val = 1; step(); step(); coef_val = 0;
        total++;
        if (coef_we !== 1'b0 || coef_rdy !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL idle_coef we=%b rdy=%b busy=%b want 0 0 0", coef_we, coef_rdy, busy);
        end
    endtask

    task automatic test_saturate();
        int d;
        for (int i = 0; i < N; i++) cf[i] = 16'($urandom);
        run_load(0, 6, -1, d);
        total++;
        if (drop2 !== 2'd3 || drop !== 16'd6) begin
            bad++; $display("FAIL saturate drop2=%0d drop=%0d want 3 6", drop2, drop);
        end
        run_flush(0);
    endtask

    task automatic test_random();
        int d, ns;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) cf[i] = 16'($urandom);
            ns = $urandom_range(0, N);
            run_load(1'($urandom % 2), ns, -1, d);
            check_coefs("rand", 0);
            total++;
            if (drop !== 16'(d) || d != ns) begin
                bad++; $display("FAIL rand_drop drop=%0d want %0d", drop, ns);
            end
            run_flush(0);
        end
    endtask

    initial begin
        test_reset();
        test_load_b2b();
        test_flush();
        test_drop();
        test_start_busy();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
